// File: rtl/noop_trap_reporter_pkg.sv
// Shared constants, state encoding and helpers for the commit-side trap reporter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trap_pkg;

    // Architectural register width; every PC and counter uses it.
    localparam int XLEN = 64;

    // Trap codes seen by the simulation monitor.
    localparam logic [31:0] TRAP_CODE_GOOD    = 32'h0000_0000;
    localparam logic [31:0] TRAP_CODE_TIMEOUT = 32'h0000_0003;
    // Monitor's "no trap" marker; the timeout path never emits it.
    localparam logic [31:0] TRAP_CODE_NONE    = 32'hFFFF_FFFF;

    // RUN counts and watches commits; TRAPPED freezes everything until reset.
    typedef enum logic {
        RUN     = 1'b0,
        TRAPPED = 1'b1
    } trap_state_e;

    // Width of a lane index; a single-lane build still needs one bit.
    function automatic int idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/noop_trap_reporter_lane_select.sv
// Picks the lowest committed trap lane and counts the valid lanes at or below it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates whatever the commit stage presents.
module trap_lane_select
    import trap_pkg::*;
#(
    parameter  int COMMIT_WIDTH = 2,
    localparam int IDX_W        = idx_width(COMMIT_WIDTH),
    localparam int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [COMMIT_WIDTH-1:0] i_valid,
    input  logic [COMMIT_WIDTH-1:0] i_is_trap,
    output logic                    o_trap_found,
    output logic [IDX_W-1:0]        o_trap_idx,
    output logic [CNT_W-1:0]        o_count_le_trap,
    output logic [IDX_W-1:0]        o_last_valid_idx,
    output logic                    o_any_valid
);

    logic [COMMIT_WIDTH-1:0] w_hits;
    logic [COMMIT_WIDTH-1:0] w_mask;
    logic [COMMIT_WIDTH-1:0] w_counted;

    assign w_hits      = i_valid & i_is_trap;
    assign w_counted   = i_valid & w_mask;
    assign o_any_valid = |i_valid;

    // Priority encoder: scan high to low so the lowest trap lane wins.
    always_comb begin
        o_trap_found = |w_hits;
        o_trap_idx   = '0;
        for (int i = COMMIT_WIDTH - 1; i >= 0; i--) begin
            if (w_hits[i]) begin
                o_trap_idx = IDX_W'(i);
            end
        end
    end

    // Lanes younger than the trap never retire; without a trap every lane counts.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_mask[i] = !o_trap_found || (i <= int'(o_trap_idx));
        end
    end

    // Masked popcount, also remembering the highest counted lane for last_pc.
    always_comb begin
        o_count_le_trap  = '0;
        o_last_valid_idx = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (w_counted[i]) begin
                o_count_le_trap  = o_count_le_trap + CNT_W'(1);
                o_last_valid_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/noop_trap_reporter.sv
// Counts cycles/retired instructions, latches the first NOOP trap or a commit-stall timeout.
// Latency: one cycle from commit to registered outputs; outputs frozen once trapped.
// Backpressure: none; commit lanes are observed every cycle and never stalled.
module noop_trap_reporter
    import trap_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int TIMEOUT      = 5000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COMMIT_WIDTH-1:0]      commit_valid,
    input  logic [COMMIT_WIDTH-1:0]      commit_is_trap,
    input  logic [COMMIT_WIDTH*XLEN-1:0] commit_pc,
    input  logic [COMMIT_WIDTH*32-1:0]   commit_code,
    output logic                         isNoopTrap,
    output logic [31:0]                  trapCode,
    output logic [XLEN-1:0]              trapPC,
    output logic [XLEN-1:0]              cycleCnt,
    output logic [XLEN-1:0]              instrCnt
);

    localparam int IDX_W  = idx_width(COMMIT_WIDTH);
    localparam int CNT_W  = $clog2(COMMIT_WIDTH + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
    // Trip one below the limit: the idle cycle that would reach TIMEOUT raises the trap.
    localparam logic [IDLE_W-1:0] IDLE_TRIP = IDLE_W'(TIMEOUT - 1);

    trap_state_e       r_state;
    logic              r_is_trap;
    logic [31:0]       r_trap_code;
    logic [XLEN-1:0]   r_trap_pc;
    logic [XLEN-1:0]   r_cycle_cnt;
    logic [XLEN-1:0]   r_instr_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [XLEN-1:0]   r_last_pc;

    logic              w_trap_found;
    logic [IDX_W-1:0]  w_trap_idx;
    logic [CNT_W-1:0]  w_count;
    logic [IDX_W-1:0]  w_last_idx;
    logic              w_any_valid;
    logic [XLEN-1:0]   w_trap_lane_pc;
    logic [31:0]       w_trap_lane_code;
    logic [XLEN-1:0]   w_last_lane_pc;
    logic [XLEN-1:0]   w_instr_inc;
    logic              w_timeout;
    logic [IDLE_W-1:0] w_idle_nxt;

    trap_lane_select #(
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_lane_select (
        .i_valid          (commit_valid),
        .i_is_trap        (commit_is_trap),
        .o_trap_found     (w_trap_found),
        .o_trap_idx       (w_trap_idx),
        .o_count_le_trap  (w_count),
        .o_last_valid_idx (w_last_idx),
        .o_any_valid      (w_any_valid)
    );

    assign w_trap_lane_pc   = commit_pc[int'(w_trap_idx) * XLEN +: XLEN];
    assign w_trap_lane_code = commit_code[int'(w_trap_idx) * 32 +: 32];
    assign w_last_lane_pc   = commit_pc[int'(w_last_idx) * XLEN +: XLEN];
    assign w_instr_inc      = XLEN'(w_count);

    // A stall trap only fires on a cycle with nothing committing at all.
    assign w_timeout = !w_any_valid && (r_idle_cnt == IDLE_TRIP);

    // Idle counter restarts on any commit and saturates at the limit.
    always_comb begin
        w_idle_nxt = r_idle_cnt;
        if (w_any_valid) begin
            w_idle_nxt = '0;
        end else if (r_idle_cnt != IDLE_MAX) begin
            w_idle_nxt = r_idle_cnt + IDLE_W'(1);
        end
    end

    // Run/trapped FSM: count while running, latch the first trap, then hold until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= RUN;
            r_is_trap   <= 1'b0;
            r_trap_code <= '0;
            r_trap_pc   <= '0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_idle_cnt  <= '0;
            r_last_pc   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + XLEN'(1);
                    r_instr_cnt <= r_instr_cnt + w_instr_inc;
                    r_idle_cnt  <= w_idle_nxt;
                    if (w_any_valid) begin
                        r_last_pc <= w_last_lane_pc;
                    end
                    if (w_trap_found) begin
                        r_trap_code <= w_trap_lane_code;
                        r_trap_pc   <= w_trap_lane_pc;
                        r_is_trap   <= 1'b1;
                        r_state     <= TRAPPED;
                    end else if (w_timeout) begin
                        r_trap_code <= TRAP_CODE_TIMEOUT;
                        r_trap_pc   <= r_last_pc;
                        r_is_trap   <= 1'b1;
                        r_state     <= TRAPPED;
                    end
                end
                TRAPPED: begin
                    r_state <= TRAPPED;
                end
            endcase
        end
    end

    assign isNoopTrap = r_is_trap;
    assign trapCode   = r_trap_code;
    assign trapPC     = r_trap_pc;
    assign cycleCnt   = r_cycle_cnt;
    assign instrCnt   = r_instr_cnt;

endmodule

// File: tb/tb_noop_trap_reporter.sv
// Scoreboard bench for noop_trap_reporter: one instance with the long default timeout,
// one with TIMEOUT=8, both driven by the same commit stream and checked every cycle,
// plus directed checks of the required values at the interesting points.
module tb_noop_trap_reporter;

    localparam int CW        = 2;
    localparam int TO_LONG   = 5000;
    localparam int TO_SHORT  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [CW-1:0]     commit_valid;
    logic [CW-1:0]     commit_is_trap;
    logic [CW*64-1:0]  commit_pc;
    logic [CW*32-1:0]  commit_code;

    logic        a_trap, b_trap;
    logic [31:0] a_code, b_code;
    logic [63:0] a_pc, b_pc, a_cyc, b_cyc, a_ins, b_ins;

    always #5 clk = ~clk;

    noop_trap_reporter #(.COMMIT_WIDTH(CW), .TIMEOUT(TO_LONG)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .commit_valid   (commit_valid),
        .commit_is_trap (commit_is_trap),
        .commit_pc      (commit_pc),
        .commit_code    (commit_code),
        .isNoopTrap     (a_trap),
        .trapCode       (a_code),
        .trapPC         (a_pc),
        .cycleCnt       (a_cyc),
        .instrCnt       (a_ins)
    );

    noop_trap_reporter #(.COMMIT_WIDTH(CW), .TIMEOUT(TO_SHORT)) u_dut_to (
        .clk            (clk),
        .reset          (reset),
        .commit_valid   (commit_valid),
        .commit_is_trap (commit_is_trap),
        .commit_pc      (commit_pc),
        .commit_code    (commit_code),
        .isNoopTrap     (b_trap),
        .trapCode       (b_code),
        .trapPC         (b_pc),
        .cycleCnt       (b_cyc),
        .instrCnt       (b_ins)
    );

    typedef struct {
        bit        trapped;
        bit [31:0] code;
        bit [63:0] pc;
        bit [63:0] cyc;
        bit [63:0] ins;
        int        idle;
        bit [63:0] last_pc;
    } model_t;

    typedef struct {
        model_t a;
        model_t b;
    } exp_t;

    model_t ma, mb;
    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference behaviour of one reporter for one clock edge.
    function automatic model_t model_step(input model_t m, input int timeout, input bit rst_n,
                                          input bit [1:0] v, input bit [1:0] t,
                                          input bit [127:0] pc, input bit [63:0] code);
        model_t n;
        bit hit;
        bit any;
        n   = m;
        hit = 1'b0;
        any = 1'b0;
        if (!rst_n) begin
            n = '{trapped: 1'b0, code: 32'h0, pc: 64'h0, cyc: 64'h0, ins: 64'h0, idle: 0, last_pc: 64'h0};
            return n;
        end
        if (m.trapped) return n;
        n.cyc = m.cyc + 64'd1;
        for (int i = 0; i < 2; i++) begin
            if (v[i] && !hit) begin
                any       = 1'b1;
                n.ins     = n.ins + 64'd1;
                n.last_pc = pc[i*64 +: 64];
                if (t[i]) begin
                    hit       = 1'b1;
                    n.trapped = 1'b1;
                    n.code    = code[i*32 +: 32];
                    n.pc      = pc[i*64 +: 64];
                end
            end
        end
        if (!any && m.idle == timeout - 1) begin
            n.trapped = 1'b1;
            n.code    = 32'h0000_0003;
            n.pc      = m.last_pc;
        end
        n.idle = any ? 0 : ((m.idle < timeout) ? m.idle + 1 : m.idle);
        return n;
    endfunction

    // Drive one cycle of stimulus, queue the expected outputs, then compare after the edge.
    task automatic step(input bit rst_n, input bit [1:0] v, input bit [1:0] t,
                        input bit [127:0] pc, input bit [63:0] code);
        exp_t e;
        reset          = rst_n;
        commit_valid   = v;
        commit_is_trap = t;
        commit_pc      = pc;
        commit_code    = code;
        ma  = model_step(ma, TO_LONG, rst_n, v, t, pc, code);
        mb  = model_step(mb, TO_SHORT, rst_n, v, t, pc, code);
        e.a = ma;
        e.b = mb;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check_eq("a.trap", 64'(a_trap), 64'(e.a.trapped));
        check_eq("a.code", 64'(a_code), 64'(e.a.code));
        check_eq("a.pc",   a_pc,        e.a.pc);
        check_eq("a.cyc",  a_cyc,       e.a.cyc);
        check_eq("a.ins",  a_ins,       e.a.ins);
        check_eq("b.trap", 64'(b_trap), 64'(e.b.trapped));
        check_eq("b.code", 64'(b_code), 64'(e.b.code));
        check_eq("b.pc",   b_pc,        e.b.pc);
        check_eq("b.cyc",  b_cyc,       e.b.cyc);
        check_eq("b.ins",  b_ins,       e.b.ins);
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 2'b00, '0, '0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 2'b00, 2'b00, '0, '0);
    endtask

    // Single non-trap commit on lane 0.
    task automatic commit0(input bit [63:0] pc);
        step(1'b1, 2'b01, 2'b00, {64'h0, pc}, 64'h0);
    endtask

    bit [63:0] snap_ins, snap_cyc;

    initial begin
        reset          = 1'b0;
        commit_valid   = '0;
        commit_is_trap = '0;
        commit_pc      = '0;
        commit_code    = '0;
        ma = '{trapped: 1'b0, code: 32'h0, pc: 64'h0, cyc: 64'h0, ins: 64'h0, idle: 0, last_pc: 64'h0};
        mb = ma;
        @(negedge clk);

        // Reset values, then 10 idle cycles and 5 single commits.
        do_reset();
        do_reset();
        check_eq("rst.trap", 64'(a_trap), 64'h0);
        check_eq("rst.code", 64'(a_code), 64'h0);
        check_eq("rst.pc",   a_pc,  64'h0);
        check_eq("rst.cyc",  a_cyc, 64'h0);
        check_eq("rst.ins",  a_ins, 64'h0);
        idle(10);
        for (int k = 0; k < 5; k++) commit0(64'h8000_0000 + 64'(4 * k));
        check_eq("t1.cyc",  a_cyc, 64'd15);
        check_eq("t1.ins",  a_ins, 64'd5);
        check_eq("t1.trap", 64'(a_trap), 64'h0);

        // Both lanes trap: lowest lane wins, only it is counted; then freeze.
        do_reset();
        for (int k = 0; k < 3; k++) commit0(64'h8000_00F0 + 64'(4 * k));
        step(1'b1, 2'b11, 2'b11, {64'h8000_0104, 64'h8000_0100}, {32'h1, 32'h0});
        check_eq("t2.trap", 64'(a_trap), 64'h1);
        check_eq("t2.pc",   a_pc, 64'h8000_0100);
        check_eq("t2.code", 64'(a_code), 64'h0);
        check_eq("t2.ins",  a_ins, 64'd4);
        check_eq("t2.cyc",  a_cyc, 64'd4);
        snap_ins = a_ins;
        snap_cyc = a_cyc;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 2'($urandom), 2'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        end
        check_eq("frz.trap", 64'(a_trap), 64'h1);
        check_eq("frz.pc",   a_pc, 64'h8000_0100);
        check_eq("frz.code", 64'(a_code), 64'h0);
        check_eq("frz.ins",  a_ins, 64'd4);
        check_eq("frz.cyc",  a_cyc, 64'd4);

        // One-cycle reset while trapped, then a fresh trap on lane 1 with the reserved code.
        do_reset();
        check_eq("rt.trap", 64'(a_trap), 64'h0);
        check_eq("rt.cyc",  a_cyc, 64'h0);
        check_eq("rt.ins",  a_ins, 64'h0);
        check_eq("rt.pc",   a_pc, 64'h0);
        idle(2);
        check_eq("rt.cnt", a_cyc, 64'd2);
        step(1'b1, 2'b11, 2'b10, {64'h9000_0004, 64'h9000_0000}, {32'hFFFF_FFFF, 32'h5});
        check_eq("rt2.trap", 64'(a_trap), 64'h1);
        check_eq("rt2.code", 64'(a_code), 64'hFFFF_FFFF);
        check_eq("rt2.pc",   a_pc, 64'h9000_0004);
        check_eq("rt2.ins",  a_ins, 64'd2);
        check_eq("rt2.cyc",  a_cyc, 64'd3);

        // TIMEOUT=8: last commit on lane 1, trap shows exactly 9 cycles later.
        do_reset();
        step(1'b1, 2'b10, 2'b00, {64'h8000_0200, 64'hDEAD_BEEF}, 64'h0);
        idle(7);
        check_eq("to.early", 64'(b_trap), 64'h0);
        idle(1);
        check_eq("to.trap", 64'(b_trap), 64'h1);
        check_eq("to.code", 64'(b_code), 64'h3);
        check_eq("to.pc",   b_pc, 64'h8000_0200);

        // A commit on the last allowed idle cycle restarts the idle count.
        do_reset();
        commit0(64'h8000_0300);
        idle(7);
        commit0(64'h8000_0304);
        check_eq("rs.none", 64'(b_trap), 64'h0);
        idle(7);
        check_eq("rs.early", 64'(b_trap), 64'h0);
        idle(1);
        check_eq("rs.trap", 64'(b_trap), 64'h1);
        check_eq("rs.pc",   b_pc, 64'h8000_0304);
        check_eq("rs.code", 64'(b_code), 64'h3);

        // Cycle counter wrap, preloaded just below 2^64.
        do_reset();
        commit0(64'h8000_0400);
        commit0(64'h8000_0404);
        force u_dut.r_cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release u_dut.r_cycle_cnt;
        ma.cyc = 64'hFFFF_FFFF_FFFF_FFFE;
        idle(1);
        check_eq("wr.max", a_cyc, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        check_eq("wr.cyc",  a_cyc, 64'h0);
        check_eq("wr.ins",  a_ins, 64'd2);
        check_eq("wr.trap", 64'(a_trap), 64'h0);
        step(1'b1, 2'b01, 2'b01, {64'h0, 64'h8000_0408}, {32'h0, 32'h7});
        check_eq("wr2.trap", 64'(a_trap), 64'h1);
        check_eq("wr2.cyc",  a_cyc, 64'd1);
        check_eq("wr2.ins",  a_ins, 64'd3);
        check_eq("wr2.code", 64'(a_code), 64'h7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/noop_trap_reporter.md
# noop_trap_reporter

Commit-side producer of the simulation trap/statistics interface. It counts cycles and retired instructions, detects the first committed NOOP trap instruction, and reports a commit-stall timeout. It drives the simulation monitor's `isNoopTrap` / `trapCode` / `trapPC` / `cycleCnt` / `instrCnt` inputs, with all outputs held stable once a trap is latched. It sits beside the commit stage and feeds the monitor every cycle.

## Interface
- `COMMIT_WIDTH`, default 2: commit lanes per cycle, 1..8.
- `TIMEOUT`, default 5000: consecutive cycles without any commit before a timeout trap is raised, at least 2.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low; logic 0 sampled at a `clk` rising edge resets the block.
- `commit_valid` in COMMIT_WIDTH: lane i retires an instruction this cycle.
- `commit_is_trap` in COMMIT_WIDTH: lane i's instruction is the NOOP trap opcode. Qualified by `commit_valid`.
- `commit_pc` in COMMIT_WIDTH*64: lane i PC in bits [64i+63:64i].
- `commit_code` in COMMIT_WIDTH*32: lane i trap code (a0 low word) in bits [32i+31:32i].
- `isNoopTrap` out 1: trap latched, sticky.
- `trapCode` out 32: latched trap code.
- `trapPC` out 64: latched trap PC.
- `cycleCnt` out 64: cycles counted in RUN.
- `instrCnt` out 64: instructions retired in RUN.

## Operation
- Two states: RUN and TRAPPED. Reset enters RUN.
- Reset values: `isNoopTrap`=0, `trapCode`=0, `trapPC`=0, `cycleCnt`=0, `instrCnt`=0. The idle counter and `last_pc` also reset to 0.
- In RUN, every cycle: `cycleCnt` += 1, wrapping modulo 2^64.
- Trap lane = lowest index i with `commit_valid[i] & commit_is_trap[i]`.
- `instrCnt` += the number of valid lanes with index ≤ trap lane. With no trap lane, it counts all valid lanes. Valid lanes above the trap lane are not counted.
- `last_pc` takes the PC of the highest counted valid lane.
- Trap lane present (RUN only):
  - latch `trapCode` = `commit_code[lane]` and `trapPC` = `commit_pc[lane]`;
  - set `isNoopTrap`;
  - go to TRAPPED.
- Idle counter:
  - any valid lane clears it to 0;
  - otherwise it increments, saturating at TIMEOUT;
  - width is $clog2(TIMEOUT+1).
- Timeout: in RUN, with the idle counter == TIMEOUT-1 and no valid lane this cycle:
  - latch `trapCode` = `TRAP_CODE_TIMEOUT` and `trapPC` = `last_pc`;
  - set `isNoopTrap`;
  - go to TRAPPED.
- TRAPPED:
  - all outputs frozen and all commit inputs ignored, including further traps;
  - only reset leaves TRAPPED.
- Reset mid-operation, in either state, returns every register to its reset value in the same edge.
- The code 32'hFFFF_FFFF is reserved as the monitor's "no trap" value and is never produced by the timeout path. A software trap code equal to it is passed through unchanged.

## Timing
- All outputs are registered; no combinational path from input to output.
- Trap committed in cycle T: at T+1, `isNoopTrap`=1 with `trapCode`/`trapPC` valid. `instrCnt` includes the trap instruction, and `cycleCnt` includes cycle T. From T+1 onward the values are constant.
- Commit in cycle T, with no commits in T+1..T+TIMEOUT: the timeout is detected in cycle T+TIMEOUT, and `isNoopTrap`=1 at T+TIMEOUT+1.
- Reset held low: outputs show reset values from the edge after the first low sample. The first RUN cycle after release counts, so `cycleCnt`=1 one cycle after release.
- `instrCnt` increment per cycle is ≤ COMMIT_WIDTH. The adder is 64-bit and wraps.

## Structure
- Package `trap_pkg` holds the shared constants:
  - `XLEN`=64;
  - `TRAP_CODE_GOOD`=32'h0;
  - `TRAP_CODE_TIMEOUT`=32'h0000_0003;
  - `TRAP_CODE_NONE`=32'hFFFF_FFFF;
  - the state enum `trap_state_e` {RUN, TRAPPED}.
- One sub-module, `trap_lane_select`: a combinational priority encoder plus a masked popcount. It outputs trap_found, trap_idx, count_le_trap, and last_valid_idx.

## Test plan
- Reset release with COMMIT_WIDTH=2: 10 idle cycles, then one commit per cycle for 5 cycles. Required: `cycleCnt`=15, `instrCnt`=5, `isNoopTrap`=0.
- Both lanes valid and both marked trap, lane0 pc 0x8000_0100 / code 0, lane1 pc 0x8000_0104 / code 1. Required next cycle: `isNoopTrap`=1, `trapPC`=0x8000_0100, `trapCode`=0, `instrCnt`+1 only. Outputs stay frozen for the following 20 cycles of random commits.
- TIMEOUT=8: last commit pc 0x8000_0200, then 8 idle cycles. Required: `isNoopTrap`=1 exactly 9 cycles after the commit, with `trapCode`=3 and `trapPC`=0x8000_0200.
- TIMEOUT=8 with a single commit after 7 idle cycles. Required: no trap; the idle counter restarts from 0.
- Reset asserted for one cycle while in TRAPPED. Required: all outputs 0 on the next cycle; counting resumes and a fresh trap is captured.
- `cycleCnt` preloaded near 2^64-1 via force. Required: wraps to 0 without affecting `instrCnt` or the trap latch.
